// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB slave that holds eight 4-byte-spaced registers starting at BASE_ADDR.
//   R0..R6 are read/write and appear on cfg_o. R7 is read-only and returns
//   status_i.
//   Each access has WAIT_CYCLES wait states, and pready_o rises in access
//   cycle WAIT_CYCLES+1. Errors reported on pslverr_o: an out-of-range offset,
//   a misaligned address, or a write to R7.
//
// Ports
//   pclk_i, prstn_i        clock, synchronous active-low reset
//   paddr_i .. pstrb_i     APB request; pprot_i is accepted and ignored
//   pready_o, prdata_o,
//   pslverr_o              APB response, all registered
//   cfg_o                  R0..R6 concatenated, R0 at the LSBs
//   status_i               read value of R7
//   dbg_state              current FSM state (0 idle, 1 wait, 2 resp)
//
// Optional feature (macro APB_SLV_PSTRB_EN)
//   When defined, writes honour pstrb_i per byte lane, and a read with a
//   nonzero pstrb_i is an error. When undefined, pstrb_i is ignored and writes
//   replace the whole register.
//
// Handshake: a transfer starts with a setup cycle (psel_i=1, penable_i=0)
//   while idle. It completes in the single cycle where pready_o=1 with psel_i
//   and penable_i still high. If psel_i drops before that cycle, the transfer
//   is abandoned and nothing is written.
module apb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic                      pclk_i,
  input  logic                      prstn_i,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic [2:0]                pprot_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [DATA_WIDTH-1:0]     pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
  output logic                      pready_o,
  output logic [DATA_WIDTH-1:0]     prdata_o,
  output logic                      pslverr_o,
  output logic [7*DATA_WIDTH-1:0]   cfg_o,
  input  logic [DATA_WIDTH-1:0]     status_i,
  output logic [1:0]                dbg_state
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] regs_q [0:6];

  logic [ADDR_WIDTH-1:0] cur_addr, offset;
  logic                  cur_write;
  logic [NB-1:0]         cur_strb;
  logic [2:0]            idx;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  setup;
  logic                  pready_d, pslverr_d, wr_en;
  logic [DATA_WIDTH-1:0] prdata_d, wr_mask;

  assign setup     = psel_i && !penable_i;
  assign dbg_state = state_q;

  // In idle the request is still on the bus and has not been latched yet.
  // With zero wait states the response is loaded at that same edge, so the
  // decode must look at the live bus inputs while idle.
  always_comb begin
    cur_addr  = (state_q == S_IDLE) ? paddr_i  : addr_q;
    cur_write = (state_q == S_IDLE) ? pwrite_i : write_q;
    cur_strb  = (state_q == S_IDLE) ? pstrb_i  : strb_q;
    offset    = cur_addr - BASE_ADDR;
    idx       = offset[4:2];
    err       = (offset > ADDR_WIDTH'(28)) || (cur_addr[1:0] != 2'b00) ||
                (cur_write && (idx == 3'd7));
`ifdef APB_SLV_PSTRB_EN
    if (!cur_write && (cur_strb != '0)) err = 1'b1;
`endif
    rd_val = (idx == 3'd7) ? status_i : regs_q[idx];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (setup) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!psel_i)                         state_d = S_IDLE;
        else if (penable_i && cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and write-enable logic, registered in the sequential block below.
  always_comb begin
    pready_d  = (state_d == S_RESP);
    pslverr_d = pready_d && err;
    prdata_d  = (pready_d && !cur_write && !err) ? rd_val : '0;
    // The write commits at the edge that ends the response cycle. It only
    // happens if the master is still selecting this slave at that edge.
    wr_en     = (state_q == S_RESP) && psel_i && write_q && !err;
    wr_mask   = '1;
`ifdef APB_SLV_PSTRB_EN
    for (int i = 0; i < NB; i++) wr_mask[i*8 +: 8] = {8{strb_q[i]}};
`endif
  end

  always_comb begin
    cfg_o = '0;
    for (int k = 0; k < 7; k++) cfg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

  // State register and all other flops
  always_ff @(posedge pclk_i) begin
    if (!prstn_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
      for (int k = 0; k < 7; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pready_o  <= pready_d;
      pslverr_o <= pslverr_d;
      prdata_o  <= prdata_d;
      if (state_q == S_IDLE && setup) begin
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        strb_q  <= pstrb_i;
        cnt_q   <= 4'(WAIT_CYCLES);
      end else if (state_q == S_WAIT && psel_i && penable_i && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (wr_en) regs_q[idx] <= (regs_q[idx] & ~wr_mask) | (wdata_q & wr_mask);
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pprot_i, cur_strb, strb_q};

endmodule
